bus_arbiter_fifo_snoop: RTL and testbench

- Parametrised successor to the 4-core common-bus arbiter. Grants the shared common bus to NUM_PROC processor-side cache requesters in strict arrival (FIFO) order.
- During a processor tenure, it interjects snoop responses from other cores (priority order) and the memory-side snoop. Each is served at most once per tenure.
- Sits between the per-core L1 controllers and the common bus / memory controller.
- All grants are registered, and reset is fully synchronous.

---
 rtl/bus_arbiter_fifo_snoop_if.sv | 29 ++
 rtl/bus_arbiter_fifo_snoop.sv | 216 +++++++++++++++++++++
 tb/tb_bus_arbiter_fifo_snoop.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_fifo_snoop_if.sv
// Common-bus handshake bundle between the L1 requesters/snoopers and the FIFO-order arbiter.
// The master modport is the requester side and the slave modport is the arbiter side.
interface bus_arbiter_fifo_snoop_if #(
    parameter int NUM_PROC  = 8,
    parameter int NUM_SNOOP = 4,
    parameter int ID_W      = $clog2(NUM_PROC)
);
    logic [NUM_PROC-1:0]  Com_Bus_Req_proc;
    logic [NUM_PROC-1:0]  Com_Bus_Gnt_proc;
    logic [NUM_SNOOP-1:0] Com_Bus_Req_snoop;
    logic [NUM_SNOOP-1:0] Com_Bus_Gnt_snoop;
    logic                 Mem_snoop_req;
    logic                 Mem_snoop_gnt;
    logic [ID_W-1:0]      owner_id;
    logic [ID_W:0]        queue_count;
    logic                 busy;

    modport master (
        output Com_Bus_Req_proc, Com_Bus_Req_snoop, Mem_snoop_req,
        input  Com_Bus_Gnt_proc, Com_Bus_Gnt_snoop, Mem_snoop_gnt,
        input  owner_id, queue_count, busy
    );

    modport slave (
        input  Com_Bus_Req_proc, Com_Bus_Req_snoop, Mem_snoop_req,
        output Com_Bus_Gnt_proc, Com_Bus_Gnt_snoop, Mem_snoop_gnt,
        output owner_id, queue_count, busy
    );
endinterface

// File: rtl/bus_arbiter_fifo_snoop.sv
// Common-bus arbiter: processor requesters are granted in arrival order, and snoop responses
// (other cores first, then memory) are interjected at most once each per processor tenure.
module bus_arbiter_fifo_snoop #(
    parameter int NUM_PROC  = 8,
    parameter int NUM_SNOOP = 4,
    parameter int ID_W      = $clog2(NUM_PROC)
) (
    input  logic                     clk,
    input  logic                     rst,
    bus_arbiter_fifo_snoop_if.slave  bus
);
    localparam int PER_CORE = NUM_PROC / NUM_SNOOP;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PROC  = 2'd1,
        ST_SNOOP = 2'd2,
        ST_MEM   = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_PROC-1:0]  prev_req_q, prev_req_d;
    logic [NUM_PROC-1:0]  pending_q, pending_d;
    logic [NUM_PROC-1:0]  queued_q, queued_d;
    logic [ID_W-1:0]      fifo_q [NUM_PROC];
    logic [ID_W-1:0]      fifo_d [NUM_PROC];
    logic [ID_W-1:0]      head_q, head_d;
    logic [ID_W-1:0]      tail_q, tail_d;
    logic [ID_W:0]        count_q, count_d;
    logic [ID_W-1:0]      owner_q, owner_d;
    logic [NUM_PROC-1:0]  gnt_proc_q, gnt_proc_d;
    logic [NUM_SNOOP-1:0] gnt_snoop_q, gnt_snoop_d;
    logic                 mem_gnt_q, mem_gnt_d;
    logic [NUM_SNOOP-1:0] snoop_served_q, snoop_served_d;
    logic                 mem_served_q, mem_served_d;
    logic                 busy_q, busy_d;

    logic [NUM_PROC-1:0]  rise_s;
    logic [NUM_PROC-1:0]  cand_s;
    logic                 push_s;
    logic                 pop_s;
    logic [ID_W-1:0]      push_id_s;
    logic [ID_W-1:0]      head_id_s;
    logic [NUM_SNOOP-1:0] own_core_mask_s;
    logic [NUM_SNOOP-1:0] snoop_cand_s;
    logic [NUM_SNOOP-1:0] snoop_pick_s;

    function automatic logic [ID_W-1:0] lowest_proc(input logic [NUM_PROC-1:0] v);
        lowest_proc = '0;
        for (int i = NUM_PROC - 1; i >= 0; i--) begin
            if (v[i]) begin
                lowest_proc = ID_W'(i);
            end
        end
    endfunction

    function automatic logic [ID_W-1:0] ptr_inc(input logic [ID_W-1:0] p);
        if (p == ID_W'(NUM_PROC - 1)) begin
            ptr_inc = '0;
        end else begin
            ptr_inc = p + 1'b1;
        end
    endfunction

    // Rise detection and the duplicate-free arrival queue.
    always_comb begin
        rise_s     = bus.Com_Bus_Req_proc & ~prev_req_q;
        cand_s     = (pending_q | rise_s) & ~queued_q;
        push_s     = |cand_s;
        push_id_s  = lowest_proc(cand_s);
        pop_s      = (state_q == ST_IDLE) && (count_q != '0);
        head_id_s  = fifo_q[head_q];
        prev_req_d = bus.Com_Bus_Req_proc;
        pending_d  = pending_q | rise_s;
        queued_d   = queued_q;
        fifo_d     = fifo_q;
        if (pop_s) begin
            queued_d[head_id_s] = 1'b0;
            head_d              = ptr_inc(head_q);
        end else begin
            head_d = head_q;
        end
        // The popped id is queued and the pushed id is not, so these never collide.
        if (push_s) begin
            pending_d[push_id_s] = 1'b0;
            queued_d[push_id_s]  = 1'b1;
            fifo_d[tail_q]       = push_id_s;
            tail_d               = ptr_inc(tail_q);
        end else begin
            tail_d = tail_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Tenure state machine: grant the queue head, interject snoops, honour the release.
    always_comb begin
        own_core_mask_s = '0;
        for (int j = 0; j < NUM_SNOOP; j++) begin
            if ((int'(owner_q) / PER_CORE) == j) begin
                own_core_mask_s[j] = 1'b1;
            end else begin
                own_core_mask_s[j] = 1'b0;
            end
        end
        snoop_cand_s   = bus.Com_Bus_Req_snoop & ~snoop_served_q & ~own_core_mask_s;
        snoop_pick_s   = snoop_cand_s & (~snoop_cand_s + 1'b1);
        state_d        = state_q;
        owner_d        = owner_q;
        gnt_proc_d     = gnt_proc_q;
        gnt_snoop_d    = gnt_snoop_q;
        mem_gnt_d      = mem_gnt_q;
        snoop_served_d = snoop_served_q;
        mem_served_d   = mem_served_q;
        case (state_q)
            ST_IDLE: begin
                if (pop_s && bus.Com_Bus_Req_proc[head_id_s]) begin
                    owner_d               = head_id_s;
                    gnt_proc_d            = '0;
                    gnt_proc_d[head_id_s] = 1'b1;
                    state_d               = ST_PROC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PROC: begin
                if (snoop_cand_s != '0) begin
                    gnt_snoop_d = snoop_pick_s;
                    state_d     = ST_SNOOP;
                end else if (bus.Mem_snoop_req && !mem_served_q) begin
                    mem_gnt_d = 1'b1;
                    state_d   = ST_MEM;
                end else if (!bus.Com_Bus_Req_proc[owner_q]) begin
                    gnt_proc_d     = '0;
                    snoop_served_d = '0;
                    mem_served_d   = 1'b0;
                    state_d        = ST_IDLE;
                end else begin
                    state_d = ST_PROC;
                end
            end
            ST_SNOOP: begin
                if ((bus.Com_Bus_Req_snoop & gnt_snoop_q) == '0) begin
                    snoop_served_d = snoop_served_q | gnt_snoop_q;
                    gnt_snoop_d    = '0;
                    state_d        = ST_PROC;
                end else begin
                    state_d = ST_SNOOP;
                end
            end
            ST_MEM: begin
                if (!bus.Mem_snoop_req) begin
                    mem_gnt_d    = 1'b0;
                    mem_served_d = 1'b1;
                    state_d      = ST_PROC;
                end else begin
                    state_d = ST_MEM;
                end
            end
            default: begin
                gnt_proc_d  = '0;
                gnt_snoop_d = '0;
                mem_gnt_d   = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State register; reset drops every grant and flushes the queue at the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            prev_req_q     <= '0;
            pending_q      <= '0;
            queued_q       <= '0;
            fifo_q         <= '{default: '0};
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            owner_q        <= '0;
            gnt_proc_q     <= '0;
            gnt_snoop_q    <= '0;
            mem_gnt_q      <= 1'b0;
            snoop_served_q <= '0;
            mem_served_q   <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            prev_req_q     <= prev_req_d;
            pending_q      <= pending_d;
            queued_q       <= queued_d;
            fifo_q         <= fifo_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            owner_q        <= owner_d;
            gnt_proc_q     <= gnt_proc_d;
            gnt_snoop_q    <= gnt_snoop_d;
            mem_gnt_q      <= mem_gnt_d;
            snoop_served_q <= snoop_served_d;
            mem_served_q   <= mem_served_d;
            busy_q         <= busy_d;
        end
    end

    assign bus.Com_Bus_Gnt_proc  = gnt_proc_q;
    assign bus.Com_Bus_Gnt_snoop = gnt_snoop_q;
    assign bus.Mem_snoop_gnt     = mem_gnt_q;
    assign bus.owner_id          = owner_q;
    assign bus.queue_count       = count_q;
    assign bus.busy              = busy_q;
endmodule

// File: tb/tb_bus_arbiter_fifo_snoop.sv
// Bench for bus_arbiter_fifo_snoop: directed scenarios plus random traffic, every cycle
// compared against a queue-based reference model of the arbitration rules.
module tb_bus_arbiter_fifo_snoop;
    localparam int NP = 8;
    localparam int NS = 4;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [NP-1:0] req_p;
    logic [NS-1:0] req_s;
    logic          mem_r;

    always #5 clk = ~clk;

    bus_arbiter_fifo_snoop_if #(.NUM_PROC(NP), .NUM_SNOOP(NS), .ID_W(IW)) bus ();

    assign bus.Com_Bus_Req_proc  = req_p;
    assign bus.Com_Bus_Req_snoop = req_s;
    assign bus.Mem_snoop_req     = mem_r;

    bus_arbiter_fifo_snoop #(.NUM_PROC(NP), .NUM_SNOOP(NS), .ID_W(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: arrival queue, pending set, and a tenure phase 0=idle 1=proc 2=snoop 3=mem.
    int            m_state;
    int            m_q[$];
    bit [NP-1:0]   m_pend, m_prev, m_gp;
    bit [NS-1:0]   m_gs, m_ss;
    bit            m_gm, m_ms;
    int            m_owner, m_sj;

    int            g_order[$];
    logic [NP-1:0] g_last;
    int            qpeak;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit in_queue(input int id);
        foreach (m_q[k]) begin
            if (m_q[k] == id) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_edge();
        bit [NP-1:0] rise, pend;
        int push_id, h, sj, ns;
        if (rst) begin
            m_state = 0; m_q.delete(); m_pend = '0; m_prev = '0; m_gp = '0;
            m_gs = '0; m_ss = '0; m_gm = 1'b0; m_ms = 1'b0; m_owner = 0; m_sj = 0;
        end else begin
            rise = req_p & ~m_prev;
            pend = m_pend | rise;
            push_id = -1;
            for (int i = 0; i < NP; i++) begin
                if (pend[i] && !in_queue(i) && push_id < 0) push_id = i;
            end
            if (push_id >= 0) pend[push_id] = 1'b0;
            ns = m_state;
            case (m_state)
                0: if (m_q.size() > 0) begin
                       h = m_q.pop_front();
                       if (req_p[h]) begin
                           m_owner = h; m_gp = '0; m_gp[h] = 1'b1; ns = 1;
                       end
                   end
                1: begin
                       sj = -1;
                       for (int j = 0; j < NS; j++) begin
                           if (req_s[j] && j != m_owner / (NP / NS) && !m_ss[j] && sj < 0) sj = j;
                       end
                       if (sj >= 0) begin
                           m_sj = sj; m_gs = '0; m_gs[sj] = 1'b1; ns = 2;
                       end else if (mem_r && !m_ms) begin
                           m_gm = 1'b1; ns = 3;
                       end else if (!req_p[m_owner]) begin
                           m_gp = '0; m_ss = '0; m_ms = 1'b0; ns = 0;
                       end
                   end
                2: if (!req_s[m_sj]) begin
                       m_gs = '0; m_ss[m_sj] = 1'b1; ns = 1;
                   end
                3: if (!mem_r) begin
                       m_gm = 1'b0; m_ms = 1'b1; ns = 1;
                   end
                default: ns = 0;
            endcase
            if (push_id >= 0) m_q.push_back(push_id);
            m_pend  = pend;
            m_prev  = req_p;
            m_state = ns;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("gnt_proc", bus.Com_Bus_Gnt_proc, m_gp);
        check_eq("gnt_snoop", bus.Com_Bus_Gnt_snoop, m_gs);
        check_eq("mem_gnt", bus.Mem_snoop_gnt, m_gm);
        check_eq("owner_id", bus.owner_id, m_owner);
        check_eq("queue_count", bus.queue_count, m_q.size());
        check_eq("busy", bus.busy, m_state != 0);
        if (bus.Com_Bus_Gnt_proc != '0 && bus.Com_Bus_Gnt_proc != g_last) begin
            for (int i = 0; i < NP; i++) begin
                if (bus.Com_Bus_Gnt_proc[i]) g_order.push_back(i);
            end
        end
        g_last = bus.Com_Bus_Gnt_proc;
        if (int'(bus.queue_count) > qpeak) qpeak = int'(bus.queue_count);
    endtask

    // Release each owner after it has held the bus for `hold` cycles, until everything drains.
    task automatic drain(input int hold, input int budget, input string tag);
        int hcnt, cyc;
        hcnt = 0;
        cyc  = 0;
        while ((m_state != 0 || m_q.size() > 0 || req_p != '0) && cyc < budget) begin
            step();
            cyc++;
            if (m_gp != '0) begin
                hcnt++;
                if (hcnt >= hold) begin
                    req_p[m_owner] = 1'b0;
                    hcnt = 0;
                end
            end else begin
                hcnt = 0;
            end
        end
        check_eq({tag, "_drain_in_budget"}, cyc < budget, 1'b1);
    endtask

    initial begin
        rst = 1'b1; req_p = '0; req_s = '0; mem_r = 1'b0; g_last = '0; qpeak = 0;
        step(); step();
        rst = 1'b0;
        step();

        // Single requester latency and release.
        req_p[3] = 1'b1;
        step();
        check_eq("single_queued", bus.queue_count, 4'd1);
        check_eq("single_no_gnt_yet", bus.Com_Bus_Gnt_proc, 8'h00);
        step();
        check_eq("single_gnt", bus.Com_Bus_Gnt_proc, 8'h08);
        check_eq("single_owner", bus.owner_id, 3'd3);
        step(); step(); step();
        req_p[3] = 1'b0;
        step();
        check_eq("single_release_gnt", bus.Com_Bus_Gnt_proc, 8'h00);
        check_eq("single_release_busy", bus.busy, 1'b0);

        // Arrival order 5, 1, 6.
        g_order.delete(); qpeak = 0;
        req_p[5] = 1'b1; step();
        req_p[1] = 1'b1; step();
        req_p[6] = 1'b1; step();
        drain(4, 200, "arrival");
        check_eq("arrival_count", g_order.size(), 3);
        if (g_order.size() == 3) begin
            check_eq("arrival_first", g_order[0], 5);
            check_eq("arrival_second", g_order[1], 1);
            check_eq("arrival_third", g_order[2], 6);
        end
        check_eq("arrival_qpeak", qpeak, 2);

        // Simultaneous rises while 0 owns the bus.
        req_p[0] = 1'b1; step(); step();
        check_eq("simul_owner0", bus.Com_Bus_Gnt_proc, 8'h01);
        g_order.delete();
        req_p[7] = 1'b1; req_p[2] = 1'b1; req_p[4] = 1'b1;
        step(); step(); step();
        check_eq("simul_queued", bus.queue_count, 4'd3);
        drain(3, 300, "simul");
        check_eq("simul_count", g_order.size(), 3);
        if (g_order.size() == 3) begin
            check_eq("simul_first", g_order[0], 2);
            check_eq("simul_second", g_order[1], 4);
            check_eq("simul_third", g_order[2], 7);
        end

        // Snoop interjection for owner 2 (core 1).
        req_p[2] = 1'b1; step(); step();
        req_s = 4'b0011; mem_r = 1'b1;
        step();
        check_eq("snoop_first_gnt", bus.Com_Bus_Gnt_snoop, 4'b0001);
        check_eq("snoop_proc_held", bus.Com_Bus_Gnt_proc, 8'h04);
        step();
        req_s[0] = 1'b0;
        step();
        step();
        check_eq("mem_gnt_after_snoop", bus.Mem_snoop_gnt, 1'b1);
        check_eq("own_core_never", bus.Com_Bus_Gnt_snoop, 4'b0000);
        mem_r = 1'b0; req_p[2] = 1'b0;
        step();
        check_eq("proc_held_mem_exit", bus.Com_Bus_Gnt_proc, 8'h04);
        step();
        check_eq("snoop_release_honoured", bus.Com_Bus_Gnt_proc, 8'h00);
        req_s = '0;
        step();

        // Once-per-tenure snoop service.
        req_p[2] = 1'b1; step();
        req_p[0] = 1'b1; step();
        req_s = 4'b1000; step();
        check_eq("once_first_gnt", bus.Com_Bus_Gnt_snoop, 4'b1000);
        req_s = 4'b0000; step();
        req_s = 4'b1000; step(); step();
        check_eq("once_no_regrant", bus.Com_Bus_Gnt_snoop, 4'b0000);
        req_p[2] = 1'b0; step(); step(); step();
        check_eq("once_next_tenure", bus.Com_Bus_Gnt_snoop, 4'b1000);
        check_eq("once_next_owner", bus.owner_id, 3'd0);
        req_s = '0; step();
        req_p[0] = 1'b0; step(); step(); step();

        // Withdrawn request is skipped.
        req_p[1] = 1'b1; step(); step();
        req_p[4] = 1'b1; step();
        check_eq("withdraw_queued", bus.queue_count, 4'd1);
        req_p[4] = 1'b0; step();
        req_p[1] = 1'b0; step(); step();
        check_eq("withdraw_busy", bus.busy, 1'b0);
        check_eq("withdraw_qcount", bus.queue_count, 4'd0);
        step();
        check_eq("withdraw_no_gnt", bus.Com_Bus_Gnt_proc, 8'h00);

        // Reset in the middle of a snoop.
        req_p[1] = 1'b1; step(); step();
        req_p[5] = 1'b1; req_s = 4'b0100; step();
        check_eq("rst_pre_snoop", bus.Com_Bus_Gnt_snoop, 4'b0100);
        rst = 1'b1; step();
        check_eq("rst_gnt_proc", bus.Com_Bus_Gnt_proc, 8'h00);
        check_eq("rst_gnt_snoop", bus.Com_Bus_Gnt_snoop, 4'b0000);
        check_eq("rst_qcount", bus.queue_count, 4'd0);
        check_eq("rst_busy", bus.busy, 1'b0);
        rst = 1'b0; req_p = '0; req_s = '0;
        step(); step();

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            step();
            rst = ($urandom_range(0, 599) == 0);
            for (int i = 0; i < NP; i++) begin
                if (!req_p[i]) begin
                    if ($urandom_range(0, 9) == 0) req_p[i] = 1'b1;
                end else if (m_gp[i]) begin
                    if ($urandom_range(0, 5) == 0) req_p[i] = 1'b0;
                end else begin
                    if ($urandom_range(0, 39) == 0) req_p[i] = 1'b0;
                end
            end
            for (int j = 0; j < NS; j++) begin
                if ($urandom_range(0, 5) == 0) req_s[j] = ~req_s[j];
            end
            if ($urandom_range(0, 7) == 0) mem_r = ~mem_r;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
